// File: rtl/tetron_placer_pkg.sv
// ============================================================================
// Module : tetron_placer_pkg
// Brief  : Shared opcodes and FSM state encoding for the tetron placer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tetron_placer_pkg;

    localparam int FIELD_W_DEF = 10;
    localparam int FIELD_H_DEF = 20;

    typedef enum logic [1:0] {
        OP_CHECK  = 2'b00,
        OP_COMMIT = 2'b01,
        OP_ERASE  = 2'b10,
        OP_CHECK2 = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RDLAST = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tetron_placer_cell_addr.sv
// ============================================================================
// Module : tetron_cell_addr
// Brief  : Anchor + sign-extended offset for one cell, with playfield bounds check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tetron_cell_addr #(
    parameter int FIELD_W = 10,
    parameter int FIELD_H = 20,
    parameter int OFS_W   = 5
) (
    input  logic [OFS_W-1:0] anchor_row,
    input  logic [OFS_W-1:0] anchor_col,
    input  logic [OFS_W-1:0] voffset,
    input  logic [OFS_W-1:0] hoffset,
    output logic [4:0]       row,
    output logic [3:0]       col,
    output logic             inb
);

    localparam int SW = OFS_W + 1;
    localparam logic signed [SW-1:0] c_row_lim = SW'(FIELD_H);
    localparam logic signed [SW-1:0] c_col_lim = SW'(FIELD_W);

    logic signed [SW-1:0] w_r;
    logic signed [SW-1:0] w_c;

    // One extra bit keeps negative results negative instead of wrapping high.
    assign w_r = $signed({1'b0, anchor_row}) + $signed({voffset[OFS_W-1], voffset});
    assign w_c = $signed({1'b0, anchor_col}) + $signed({hoffset[OFS_W-1], hoffset});

    assign inb = !w_r[SW-1] && (w_r < c_row_lim) && !w_c[SW-1] && (w_c < c_col_lim);
    assign row = w_r[4:0];
    assign col = w_c[3:0];

endmodule

`default_nettype wire

// File: rtl/tetron_placer.sv
// ============================================================================
// Module : tetron_placer
// Brief  : Bounds-checks and collision-checks a four-block piece against the
//          playfield RAM; COMMIT writes the piece colour when no collision.
//          Define TETRON_PLACER_ERASE_EN to enable the op=10 erase path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tetron_placer
    import tetron_placer_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF,
    parameter int OFS_W   = 5,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [1:0]         op,
    input  logic [OFS_W-1:0]   anchor_row,
    input  logic [OFS_W-1:0]   anchor_col,
    input  logic [OFS_W-1:0]   blk1_voffset,
    input  logic [OFS_W-1:0]   blk1_hoffset,
    input  logic [OFS_W-1:0]   blk2_voffset,
    input  logic [OFS_W-1:0]   blk2_hoffset,
    input  logic [OFS_W-1:0]   blk3_voffset,
    input  logic [OFS_W-1:0]   blk3_hoffset,
    input  logic [OFS_W-1:0]   blk4_voffset,
    input  logic [OFS_W-1:0]   blk4_hoffset,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic               collide,
    output logic               fld_rd_en,
    output logic               fld_we,
    output logic [4:0]         fld_row,
    output logic [3:0]         fld_col,
    input  logic [COLOR_W-1:0] fld_rdata,
    output logic [COLOR_W-1:0] fld_wdata
);

    state_t             r_state;
    logic [1:0]         r_idx;
    logic               r_commit;
    logic               r_erase;
    logic               r_rd_pend;
    logic [OFS_W-1:0]   r_arow;
    logic [OFS_W-1:0]   r_acol;
    logic [OFS_W-1:0]   r_voff [4];
    logic [OFS_W-1:0]   r_hoff [4];
    logic [COLOR_W-1:0] r_color;

    logic               w_erase_req;
    logic               w_hit;
    logic [4:0]         w_row;
    logic [3:0]         w_col;
    logic               w_inb;

`ifdef TETRON_PLACER_ERASE_EN
    assign w_erase_req = (op == OP_ERASE);
`else
    assign w_erase_req = 1'b0;
`endif

    // Read data belongs to the slot issued in the previous cycle.
    assign w_hit = r_rd_pend && (fld_rdata != {COLOR_W{1'b0}});

    tetron_cell_addr #(
        .FIELD_W (FIELD_W),
        .FIELD_H (FIELD_H),
        .OFS_W   (OFS_W)
    ) u_cell_addr (
        .anchor_row (r_arow),
        .anchor_col (r_acol),
        .voffset    (r_voff[r_idx]),
        .hoffset    (r_hoff[r_idx]),
        .row        (w_row),
        .col        (w_col),
        .inb        (w_inb)
    );

    always_comb begin
        fld_rd_en = 1'b0;
        fld_we    = 1'b0;
        fld_row   = 5'd0;
        fld_col   = 4'd0;
        fld_wdata = {COLOR_W{1'b0}};
        if (r_state == ST_RD) begin
            fld_rd_en = w_inb;
            if (w_inb) begin
                fld_row = w_row;
                fld_col = w_col;
            end
        end else if (r_state == ST_WR) begin
            fld_we    = w_inb;
            fld_wdata = r_erase ? {COLOR_W{1'b0}} : r_color;
            if (w_inb) begin
                fld_row = w_row;
                fld_col = w_col;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_commit  <= 1'b0;
            r_erase   <= 1'b0;
            r_rd_pend <= 1'b0;
            r_arow    <= '0;
            r_acol    <= '0;
            r_color   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_voff[i] <= '0;
                r_hoff[i] <= '0;
            end
            busy      <= 1'b0;
            done      <= 1'b0;
            collide   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_commit  <= (op == OP_COMMIT);
                        r_erase   <= w_erase_req;
                        r_arow    <= anchor_row;
                        r_acol    <= anchor_col;
                        r_voff[0] <= blk1_voffset;
                        r_hoff[0] <= blk1_hoffset;
                        r_voff[1] <= blk2_voffset;
                        r_hoff[1] <= blk2_hoffset;
                        r_voff[2] <= blk3_voffset;
                        r_hoff[2] <= blk3_hoffset;
                        r_voff[3] <= blk4_voffset;
                        r_hoff[3] <= blk4_hoffset;
                        r_color   <= color;
                        r_idx     <= 2'd0;
                        r_rd_pend <= 1'b0;
                        collide   <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= w_erase_req ? ST_WR : ST_RD;
                    end
                end
                ST_RD: begin
                    r_rd_pend <= w_inb;
                    if (!w_inb || w_hit) begin
                        collide <= 1'b1;
                    end
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state <= ST_RDLAST;
                    end
                end
                ST_RDLAST: begin
                    r_rd_pend <= 1'b0;
                    if (w_hit) begin
                        collide <= 1'b1;
                    end
                    if (r_commit && !collide && !w_hit) begin
                        r_state <= ST_WR;
                    end else begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_WR: begin
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
